// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: runs loads/stores over a req/ack handshake and freezes the pipeline until done.
// Optional ack timeout with sticky error flag is built when MEM_ACC_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] ReadData_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        acc;

    assign acc = MemRead_i | MemWrite_i;

`ifdef MEM_ACC_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        expire;

    // Expiry fires in the BUSY cycle whose increment would bring the counter to TIMEOUT.
    assign expire = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic [31:0] timeout_unused;

    assign timeout_unused = TIMEOUT;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall_o = 1'b0;
`ifdef MEM_ACC_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc) begin
                    stall_o = 1'b1;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    req_d   = 1'b1;
                    state_d = BUSY;
`ifdef MEM_ACC_TIMEOUT_EN
                    cnt_d   = 16'd0;
`endif
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
`ifdef MEM_ACC_TIMEOUT_EN
                end else if (expire) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            // Inputs still show the finished instruction here, so never start a new access.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign ReadData_o  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the timeout scenario is included when MEM_ACC_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] ReadData_o;
    logic        stall_o;
    logic        err_o;

    int testsRun    = 0;
    int testsFailed = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .ReadData_o (ReadData_o),
        .stall_o    (stall_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        addr_i      = a;
        wdata_i     = wd;
        mem_ack_i   = ack;
        mem_rdata_i = rdat;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each cycle: wait for the falling edge, drive inputs, let combinational stall settle, then check.
    task automatic nextCycle(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
        @(negedge clk_i);
        applyStimulus(rd, wr, a, wd, ack, rdat);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_req", mem_req_o, 32'h0);
        checkOutput("rst_we", mem_we_o, 32'h0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        checkOutput("rst_wdata", mem_wdata_o, 32'h0);
        checkOutput("rst_rdata", ReadData_o, 32'h0);
        checkOutput("rst_stall", stall_o, 32'h0);
        checkOutput("rst_err", err_o, 32'h0);

        @(negedge clk_i);
        rst_i = 1'b0;

        // Load with ack in the third BUSY cycle: stall 4 cycles, req 3 cycles.
        nextCycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
        checkOutput("ld_idle_stall", stall_o, 32'h1);
        checkOutput("ld_idle_req", mem_req_o, 32'h0);
        nextCycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
        checkOutput("ld_b1_req", mem_req_o, 32'h1);
        checkOutput("ld_b1_we", mem_we_o, 32'h0);
        checkOutput("ld_b1_addr", mem_addr_o, 32'h0000_0010);
        checkOutput("ld_b1_stall", stall_o, 32'h1);
        nextCycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
        checkOutput("ld_b2_req", mem_req_o, 32'h1);
        checkOutput("ld_b2_stall", stall_o, 32'h1);
        nextCycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);
        checkOutput("ld_b3_req", mem_req_o, 32'h1);
        checkOutput("ld_b3_stall", stall_o, 32'h1);
        nextCycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
        checkOutput("ld_done_req", mem_req_o, 32'h0);
        checkOutput("ld_done_stall", stall_o, 32'h0);
        checkOutput("ld_done_rdata", ReadData_o, 32'h1234_5678);

        // Store with ack in the first BUSY cycle; bogus rdata must not be captured.
        nextCycle(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h0);
        checkOutput("st_idle_no_restart", mem_req_o, 32'h0);
        checkOutput("st_idle_stall", stall_o, 32'h1);
        nextCycle(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF);
        checkOutput("st_b1_req", mem_req_o, 32'h1);
        checkOutput("st_b1_we", mem_we_o, 32'h1);
        checkOutput("st_b1_wdata", mem_wdata_o, 32'hCAFE_F00D);
        checkOutput("st_b1_addr", mem_addr_o, 32'h0000_0020);
        checkOutput("st_b1_stall", stall_o, 32'h1);
        nextCycle(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h0);
        checkOutput("st_done_stall", stall_o, 32'h0);
        checkOutput("st_done_req", mem_req_o, 32'h0);
        checkOutput("st_done_rdata_kept", ReadData_o, 32'h1234_5678);

        // Back-to-back loads returning 0xA then 0xB.
        nextCycle(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0, 32'h0);
        checkOutput("bb1_idle_req", mem_req_o, 32'h0);
        checkOutput("bb1_idle_stall", stall_o, 32'h1);
        nextCycle(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b1, 32'h0000_000A);
        checkOutput("bb1_b1_req", mem_req_o, 32'h1);
        checkOutput("bb1_b1_we", mem_we_o, 32'h0);
        checkOutput("bb1_b1_addr", mem_addr_o, 32'h0000_0030);
        nextCycle(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0, 32'h0);
        checkOutput("bb1_done_rdata", ReadData_o, 32'h0000_000A);
        checkOutput("bb1_done_stall", stall_o, 32'h0);
        checkOutput("bb1_done_req", mem_req_o, 32'h0);
        nextCycle(1'b1, 1'b0, 32'h0000_0034, 32'h0, 1'b0, 32'h0);
        checkOutput("bb2_idle_req", mem_req_o, 32'h0);
        checkOutput("bb2_idle_stall", stall_o, 32'h1);
        nextCycle(1'b1, 1'b0, 32'h0000_0034, 32'h0, 1'b1, 32'h0000_000B);
        checkOutput("bb2_b1_req", mem_req_o, 32'h1);
        checkOutput("bb2_b1_addr", mem_addr_o, 32'h0000_0034);
        nextCycle(1'b1, 1'b0, 32'h0000_0034, 32'h0, 1'b0, 32'h0);
        checkOutput("bb2_done_rdata", ReadData_o, 32'h0000_000B);
        checkOutput("bb2_done_stall", stall_o, 32'h0);

        // Non-memory instruction and a stray ack in IDLE.
        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("nomem_stall", stall_o, 32'h0);
        checkOutput("nomem_req", mem_req_o, 32'h0);
        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0055);
        checkOutput("stray_ack_stall", stall_o, 32'h0);
        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("stray_ack_rdata", ReadData_o, 32'h0000_000B);
        checkOutput("stray_ack_req", mem_req_o, 32'h0);

        // Reset asserted mid-access, late ack afterwards.
        nextCycle(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        checkOutput("abort_idle_stall", stall_o, 32'h1);
        nextCycle(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        checkOutput("abort_busy_req", mem_req_o, 32'h1);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("abort_async_req", mem_req_o, 32'h0);
        checkOutput("abort_async_rdata", ReadData_o, 32'h0);
        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst_i = 1'b0;
        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0077);
        checkOutput("late_ack_stall", stall_o, 32'h0);
        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("late_ack_req", mem_req_o, 32'h0);
        checkOutput("late_ack_rdata", ReadData_o, 32'h0);
        checkOutput("late_ack_stall2", stall_o, 32'h0);

        // A fresh load after the abort proves the controller is back in IDLE.
        nextCycle(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b0, 32'h0);
        checkOutput("post_idle_stall", stall_o, 32'h1);
        checkOutput("post_idle_req", mem_req_o, 32'h0);
        nextCycle(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b1, 32'h0000_0099);
        checkOutput("post_b1_req", mem_req_o, 32'h1);
        checkOutput("post_b1_addr", mem_addr_o, 32'h0000_0050);
        nextCycle(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b0, 32'h0);
        checkOutput("post_done_rdata", ReadData_o, 32'h0000_0099);
        checkOutput("post_done_stall", stall_o, 32'h0);
        checkOutput("post_err", err_o, 32'h0);

`ifdef MEM_ACC_TIMEOUT_EN
        // Load with no ack: expires after 4 BUSY cycles.
        nextCycle(1'b1, 1'b0, 32'h0000_0060, 32'h0, 1'b0, 32'h0);
        checkOutput("to_idle_stall", stall_o, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            nextCycle(1'b1, 1'b0, 32'h0000_0060, 32'h0, 1'b0, 32'h0);
            checkOutput($sformatf("to_busy%0d_stall", i), stall_o, 32'h1);
            checkOutput($sformatf("to_busy%0d_req", i), mem_req_o, 32'h1);
            checkOutput($sformatf("to_busy%0d_err", i), err_o, 32'h0);
        end
        nextCycle(1'b1, 1'b0, 32'h0000_0060, 32'h0, 1'b0, 32'h0);
        checkOutput("to_done_err", err_o, 32'h1);
        checkOutput("to_done_rdata", ReadData_o, 32'h0);
        checkOutput("to_done_stall", stall_o, 32'h0);
        checkOutput("to_done_req", mem_req_o, 32'h0);
        nextCycle(1'b0, 1'b1, 32'h0000_0064, 32'h1111_2222, 1'b0, 32'h0);
        checkOutput("to_next_idle_stall", stall_o, 32'h1);
        nextCycle(1'b0, 1'b1, 32'h0000_0064, 32'h1111_2222, 1'b1, 32'h0);
        checkOutput("to_next_b1_req", mem_req_o, 32'h1);
        nextCycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("to_err_sticky", err_o, 32'h1);
        checkOutput("to_next_done_stall", stall_o, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
